// File: rtl/clk_tick_pkg.sv
// ---------------------------------------------------------------------------
// clk_tick_pkg
//
// Shared definitions for the multi-channel clock-enable generator.
//
// Contents:
//   PKG_DIV_W        default divisor / counter width in bits
//   PKG_DEFAULT_DIV  default divisor loaded into every channel at reset
//   ch_mode_e        what a channel does on a given rising edge
//   clamp_div()      maps raw divisor values 0 and 1 to an effective N of 1
// ---------------------------------------------------------------------------
package clk_tick_pkg;

  localparam int PKG_DIV_W       = 16;
  localparam int PKG_DEFAULT_DIV = 128;

  // Per-edge channel activity, in decreasing priority:
  //   CH_SYNC  realign: reload the counter and clear both outputs
  //   CH_HOLD  channel disabled: counter parked at N-1, outputs low
  //   CH_TERM  terminal count: emit a tick, toggle the square wave, reload
  //   CH_COUNT ordinary down-count
  typedef enum logic [1:0] {
    CH_HOLD  = 2'd0,
    CH_COUNT = 2'd1,
    CH_TERM  = 2'd2,
    CH_SYNC  = 2'd3
  } ch_mode_e;

  // A divisor of 0 or 1 both mean "tick every cycle". Callers with a
  // narrower divisor zero-extend into and truncate back out of 32 bits.
  function automatic logic [31:0] clamp_div(input logic [31:0] raw);
    return (raw < 32'd2) ? 32'd1 : raw;
  endfunction

endpackage

// File: rtl/clk_tick_chan.sv
// ---------------------------------------------------------------------------
// clk_tick_chan
//
// One channel of the clock-enable generator: a down-counter, the active
// divisor, a staged (pending) divisor, and the registered tick / square-wave
// outputs.
//
// Ports:
//   clk_i       oscillator clock
//   rst_i       asynchronous reset, active-high
//   en_i        run enable for this channel
//   sync_i      realign pulse (shared by all channels)
//   load_i      divisor write while the channel is disabled: apply at once
//   stage_i     divisor write while the channel is enabled: stage for later
//   val_i       divisor value accompanying load_i / stage_i
//   tick_o      one-cycle strobe every N enabled cycles
//   sq_o        square wave, period 2N, toggles on every tick
//   upd_pend_o  a staged divisor is waiting for the next terminal count
// ---------------------------------------------------------------------------
module clk_tick_chan
  import clk_tick_pkg::*;
#(
  parameter int DIV_W       = PKG_DIV_W,
  parameter int DEFAULT_DIV = PKG_DEFAULT_DIV
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic             stage_i,
  input  logic [DIV_W-1:0] val_i,
  output logic             tick_o,
  output logic             sq_o,
  output logic             upd_pend_o
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] RST_CNT = DIV_W'(DEFAULT_DIV - 1);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             upd_pend_q, upd_pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  // Divisor/pending state as seen after this edge's write is folded in.
  logic [DIV_W-1:0] divEff;
  logic [DIV_W-1:0] pendEff;
  logic             pendingEff;
  ch_mode_e         mode;

  // Effective N for a raw divisor value, at the channel's own width.
  function automatic logic [DIV_W-1:0] clampN(input logic [DIV_W-1:0] raw);
    return DIV_W'(clamp_div(32'(raw)));
  endfunction

  // Classify the coming edge. sync outranks everything so that a
  // realign never lets a terminal-count tick slip out on the same edge.
  always_comb begin
    mode = CH_COUNT;
    if (sync_i) begin
      mode = CH_SYNC;
    end else if (!en_i) begin
      mode = CH_HOLD;
    end else if (cnt_q == '0) begin
      mode = CH_TERM;
    end
  end

  // Next-state logic. A write on this edge is folded in first (divEff /
  // pendEff / pendingEff), then the mode decides what the counter does.
  // That ordering is what lets a write coinciding with sync take effect
  // immediately, while a write at a terminal count waits for the next one
  // so the tick on this edge still uses the old N.
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    upd_pend_d = upd_pend_q;
    tick_d     = 1'b0;
    sq_d       = sq_q;

    divEff     = div_q;
    pendEff    = pend_q;
    pendingEff = upd_pend_q;
    if (load_i) begin
      divEff     = val_i;
      pendingEff = 1'b0;
    end
    if (stage_i) begin
      pendEff    = val_i;
      pendingEff = 1'b1;
    end

    unique case (mode)
      CH_SYNC, CH_HOLD: begin
        // Nothing to wait for when realigning or parked: any staged value
        // becomes the active divisor right now.
        div_d      = pendingEff ? pendEff : divEff;
        cnt_d      = clampN(div_d) - ONE;
        pend_d     = pendEff;
        upd_pend_d = 1'b0;
        sq_d       = 1'b0;
      end
      CH_TERM: begin
        // A value staged on an earlier edge is applied here; one arriving
        // on this very edge is held for the following terminal count.
        tick_d     = 1'b1;
        sq_d       = ~sq_q;
        div_d      = upd_pend_q ? pend_q : divEff;
        cnt_d      = clampN(div_d) - ONE;
        upd_pend_d = 1'b0;
        if (stage_i) begin
          pend_d     = val_i;
          upd_pend_d = 1'b1;
        end
      end
      default: begin
        cnt_d      = cnt_q - ONE;
        div_d      = divEff;
        pend_d     = pendEff;
        upd_pend_d = pendingEff;
      end
    endcase
  end

  // State register. Reset discards any staged divisor and parks the
  // counter at DEFAULT_DIV-1 so the first tick lands on the N-th edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= RST_CNT;
      div_q      <= RST_DIV;
      pend_q     <= '0;
      upd_pend_q <= 1'b0;
      tick_q     <= 1'b0;
      sq_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      upd_pend_q <= upd_pend_d;
      tick_q     <= tick_d;
      sq_q       <= sq_d;
    end
  end

  assign tick_o     = tick_q;
  assign sq_o       = sq_q;
  assign upd_pend_o = upd_pend_q;

endmodule

// File: rtl/clk_tick_gen.sv
// ---------------------------------------------------------------------------
// clk_tick_gen
//
// Multi-channel clock-enable generator. Each channel produces a one-cycle
// tick every N cycles and a 50%-duty square wave of period 2N; N can be
// rewritten at runtime without glitching the running period.
//
// Ports:
//   clk_i       oscillator clock
//   rst_i       asynchronous reset, active-high
//   en_i        per-channel run enable
//   sync_i      realign every channel (single-cycle pulse)
//   div_wr_i    divisor write strobe
//   div_ch_i    target channel of the write
//   div_val_i   new divisor (0 and 1 both mean N=1)
//   div_err_o   registered one-cycle pulse: write addressed a missing channel
//   tick_o      per-channel registered tick strobe
//   sq_o        per-channel registered square wave
//   upd_pend_o  per-channel "divisor staged, not yet applied"
// ---------------------------------------------------------------------------
module clk_tick_gen
  import clk_tick_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = PKG_DIV_W,
  parameter int DEFAULT_DIV = PKG_DEFAULT_DIV,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  input  logic              div_wr_i,
  input  logic [CH_W-1:0]   div_ch_i,
  input  logic [DIV_W-1:0]  div_val_i,
  output logic              div_err_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] sq_o,
  output logic [NUM_CH-1:0] upd_pend_o
);

  logic              chValid;
  logic [NUM_CH-1:0] wrSel;
  logic [NUM_CH-1:0] loadSel;
  logic [NUM_CH-1:0] stageSel;
  logic              div_err_q, div_err_d;

  // When NUM_CH is not a power of two some select codes name no channel;
  // such writes are dropped and flagged instead.
  assign chValid = (32'(div_ch_i) < NUM_CH);

  // Address decode. A disabled channel takes the new divisor at once;
  // an enabled one stages it so its current period completes unchanged.
  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    assign wrSel[g]    = div_wr_i && chValid && (div_ch_i == CH_W'(g));
    assign loadSel[g]  = wrSel[g] && !en_i[g];
    assign stageSel[g] = wrSel[g] &&  en_i[g];

    clk_tick_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (en_i[g]),
      .sync_i     (sync_i),
      .load_i     (loadSel[g]),
      .stage_i    (stageSel[g]),
      .val_i      (div_val_i),
      .tick_o     (tick_o[g]),
      .sq_o       (sq_o[g]),
      .upd_pend_o (upd_pend_o[g])
    );
  end

  // The error flag is recomputed every edge, so it stays high for exactly
  // one cycle per bad write.
  assign div_err_d = div_wr_i && !chValid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_err_q <= 1'b0;
    end else begin
      div_err_q <= div_err_d;
    end
  end

  assign div_err_o = div_err_q;

endmodule

// File: tb/tb_clk_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_tick_gen
//
// Self-checking bench for clk_tick_gen. Expected outputs are hand-derived
// per edge, pushed to a scoreboard queue as each stimulus vector is driven
// and popped when the registered outputs are sampled after the edge.
// A second 3-channel instance covers the out-of-range select.
// ---------------------------------------------------------------------------
module tb_clk_tick_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        sync;
  logic        divWr;
  logic [1:0]  divCh;
  logic [15:0] divVal;
  logic        divErr;
  logic [3:0]  tick;
  logic [3:0]  sq;
  logic [3:0]  updPend;

  logic [2:0]  en3;
  logic        sync3;
  logic        wr3;
  logic [1:0]  ch3;
  logic [15:0] val3;
  logic        err3;
  logic [2:0]  tick3;
  logic [2:0]  sq3;
  logic [2:0]  upd3;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    string       tag;
    logic [3:0]  en;
    logic        sync;
    logic        wr;
    logic [1:0]  ch;
    logic [15:0] val;
    logic [3:0]  mask;
    logic [3:0]  tick;
    logic [3:0]  sq;
    logic [3:0]  upd;
  } vec_t;

  typedef struct {
    string      tag;
    int         idx;
    logic [3:0] mask;
    logic [3:0] tick;
    logic [3:0] sq;
    logic [3:0] upd;
    logic       err;
  } exp_t;

  exp_t sb[$];
  vec_t tab[$];

  always #5 clk = ~clk;

  clk_tick_gen #(
    .NUM_CH      (4),
    .DIV_W       (16),
    .DEFAULT_DIV (128)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .sync_i     (sync),
    .div_wr_i   (divWr),
    .div_ch_i   (divCh),
    .div_val_i  (divVal),
    .div_err_o  (divErr),
    .tick_o     (tick),
    .sq_o       (sq),
    .upd_pend_o (updPend)
  );

  clk_tick_gen #(
    .NUM_CH      (3),
    .DIV_W       (16),
    .DEFAULT_DIV (4)
  ) dut3 (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en3),
    .sync_i     (sync3),
    .div_wr_i   (wr3),
    .div_ch_i   (ch3),
    .div_val_i  (val3),
    .div_err_o  (err3),
    .tick_o     (tick3),
    .sq_o       (sq3),
    .upd_pend_o (upd3)
  );

  function automatic vec_t mkVec(input string tag, input logic [3:0] enV,
                                 input logic syncV, input logic wrV,
                                 input logic [1:0] chV, input logic [15:0] valV,
                                 input logic [3:0] maskV, input logic [3:0] tickV,
                                 input logic [3:0] sqV, input logic [3:0] updV);
    vec_t v;
    v.tag = tag; v.en = enV; v.sync = syncV; v.wr = wrV; v.ch = chV;
    v.val = valV; v.mask = maskV; v.tick = tickV; v.sq = sqV; v.upd = updV;
    return v;
  endfunction

  task automatic compareBits(input string name, input int idx, input logic [3:0] act,
                             input logic [3:0] expv, input logic [3:0] mask);
    checkCount++;
    if ((act & mask) !== (expv & mask)) begin
      failCount++;
      $display("[TB] FAIL %s #%0d: got %b, expected %b (mask %b)", name, idx, act, expv, mask);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL scoreboard: empty on sample, got tick=%b expected an entry", tick);
      return;
    end
    e = sb.pop_front();
    compareBits({e.tag, ".tick"}, e.idx, tick, e.tick, e.mask);
    compareBits({e.tag, ".sq"}, e.idx, sq, e.sq, e.mask);
    compareBits({e.tag, ".upd"}, e.idx, updPend, e.upd, e.mask);
    compareBits({e.tag, ".err"}, e.idx, {3'b000, divErr}, {3'b000, e.err}, 4'b0001);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    en = v.en; sync = v.sync; divWr = v.wr; divCh = v.ch; divVal = v.val;
    e.tag = v.tag; e.idx = idx; e.mask = v.mask;
    e.tick = v.tick; e.sq = v.sq; e.upd = v.upd; e.err = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runTable();
    for (int i = 0; i < tab.size(); i++) begin
      applyStimulus(tab[i], i + 1);
    end
    tab.delete();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  tk, sqv, up, m;
    logic        s, w;
    logic [15:0] v;
    logic [2:0]  exp3;

    rst = 1'b1; en = '0; sync = 1'b0; divWr = 1'b0; divCh = '0; divVal = '0;
    en3 = '0; sync3 = 1'b0; wr3 = 1'b0; ch3 = '0; val3 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    compareBits("reset.tick", 0, tick, 4'h0, 4'hF);
    compareBits("reset.sq", 0, sq, 4'h0, 4'hF);
    compareBits("reset.upd", 0, updPend, 4'h0, 4'hF);
    compareBits("reset.err", 0, {3'b000, divErr}, 4'h0, 4'h1);
    rst = 1'b0;
    $display("[TB] reset released");

    // Default divisor 128 on channel 0
    applyStimulus(mkVec("idle", 4'h0, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0), 0);
    for (int k = 1; k <= 300; k++) begin
      tk = {3'b000, (k % 128) == 0};
      sqv = {3'b000, ((k / 128) % 2) == 1};
      applyStimulus(mkVec("def128", 4'h1, 0, 0, 0, 0, 4'hF, tk, sqv, 4'h0), k);
    end
    applyStimulus(mkVec("disable0", 4'h0, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0), 0);

    // Channel 1: N=4, restaged to 6 mid-period
    applyStimulus(mkVec("load1", 4'h0, 0, 1, 2'd1, 16'd4, 4'hF, 4'h0, 4'h0, 4'h0), 0);
    for (int k = 1; k <= 20; k++) begin
      tk = '0; sqv = '0; up = '0;
      w = (k == 6);
      tk[1]  = k inside {4, 8, 14, 20};
      sqv[1] = k inside {[4:7], [14:19]};
      up[1]  = k inside {6, 7};
      tab.push_back(mkVec("restage", 4'h2, 0, w, 2'd1, w ? 16'd6 : 16'd0, 4'hF, tk, sqv, up));
    end
    runTable();
    applyStimulus(mkVec("disable1", 4'h0, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0), 0);

    // Channel 2 divisor 0 (clamped to 1), channel 3 divisor 2
    applyStimulus(mkVec("load2", 4'h0, 0, 1, 2'd2, 16'd0, 4'hF, 4'h0, 4'h0, 4'h0), 0);
    applyStimulus(mkVec("load3", 4'h0, 0, 1, 2'd3, 16'd2, 4'hF, 4'h0, 4'h0, 4'h0), 0);
    for (int k = 1; k <= 6; k++) begin
      tk = {(k % 2) == 0, 1'b1, 2'b00};
      sqv = {((k / 2) % 2) == 1, (k % 2) == 1, 2'b00};
      tab.push_back(mkVec("div0", 4'hC, 0, 0, 0, 0, 4'hF, tk, sqv, 4'h0));
    end
    runTable();
    applyStimulus(mkVec("disable23", 4'h0, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0), 0);

    // Sync realign, write at terminal count, sync+write, repeated writes
    applyStimulus(mkVec("load0", 4'h0, 0, 1, 2'd0, 16'd3, 4'hF, 4'h0, 4'h0, 4'h0), 0);
    applyStimulus(mkVec("load1b", 4'h0, 0, 1, 2'd1, 16'd5, 4'hF, 4'h0, 4'h0, 4'h0), 0);
    for (int k = 1; k <= 30; k++) begin
      tk = '0; sqv = '0; up = '0;
      s = (k == 6) || (k == 18);
      w = k inside {12, 18, 24, 25};
      v = (k == 12) ? 16'd2 : (k == 18) ? 16'd5 : (k == 24) ? 16'd7 : (k == 25) ? 16'd2 : 16'd0;
      tk[0]  = k inside {3, 9, 12, 15, 17, 23, 28, 30};
      sqv[0] = k inside {[3:5], [9:11], [15:16], [23:27], 30};
      up[0]  = k inside {[12:14], [24:27]};
      tk[1]  = k inside {5, 11};
      sqv[1] = k inside {5, 11};
      m = (k <= 11) ? 4'b0011 : 4'b0001;
      tab.push_back(mkVec("sync", 4'h3, s, w, 2'd0, v, m, tk, sqv, up));
    end
    runTable();

    // Reset while a divisor is pending and channels are ticking
    applyStimulus(mkVec("stage9", 4'h3, 0, 1, 2'd0, 16'd9, 4'h1, 4'h0, 4'h1, 4'h1), 31);
    divWr = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    compareBits("rstmid.tick", 0, tick, 4'h0, 4'hF);
    compareBits("rstmid.sq", 0, sq, 4'h0, 4'hF);
    compareBits("rstmid.upd", 0, updPend, 4'h0, 4'hF);
    @(posedge clk);
    #1;
    compareBits("rsthold.tick", 0, tick, 4'h0, 4'hF);
    compareBits("rsthold.upd", 0, updPend, 4'h0, 4'hF);
    en = '0;
    rst = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      tk = {3'b000, k == 128};
      sqv = {3'b000, k >= 128};
      applyStimulus(mkVec("postrst", 4'h1, 0, 0, 0, 0, 4'hF, tk, sqv, 4'h0), k);
    end
    en = '0;

    // Three-channel instance: select code 3 names no channel
    wr3 = 1'b1; ch3 = 2'd3; val3 = 16'd9;
    @(posedge clk);
    #1;
    compareBits("err3.pulse", 0, {3'b000, err3}, 4'h1, 4'h1);
    wr3 = 1'b1; ch3 = 2'd2; val3 = 16'd2;
    @(posedge clk);
    #1;
    compareBits("err3.single", 0, {3'b000, err3}, 4'h0, 4'h1);
    wr3 = 1'b0;
    en3 = 3'b111;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      exp3 = {(k % 2) == 0, k == 4, k == 4};
      compareBits("err3.divs", k, {1'b0, tick3}, {1'b0, exp3}, 4'h7);
      compareBits("err3.noerr", k, {3'b000, err3}, 4'h0, 4'h1);
    end
    compareBits("err3.upd", 0, {1'b0, upd3}, 4'h0, 4'h7);

    if (sb.size() != 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL scoreboard: got %0d leftover entries, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
